// File: rtl/ifetch_prefetch_if.sv
// Fetch unit bus bundle: memory request/response, instruction queue head and ROB redirect.
// The master modport is the prefetcher; the slave modport is its environment.
interface ifetch_prefetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              ram_bus_rdy_in;
  logic              ram_bus_en_out;
  logic [ADDR_W-1:0] ram_bus_pc_out;
  logic              ram_bus_en_in;
  logic [INST_W-1:0] ram_bus_inst_in;
  logic              instqueue_rdy_in;
  logic              instqueue_inst_en_out;
  logic [INST_W-1:0] instqueue_inst_out;
  logic [ADDR_W-1:0] instqueue_pc_out;
  logic              rob_en_in;
  logic [ADDR_W-1:0] rob_pc_in;

  modport master (
    input  ram_bus_rdy_in, ram_bus_en_in, ram_bus_inst_in, instqueue_rdy_in, rob_en_in, rob_pc_in,
    output ram_bus_en_out, ram_bus_pc_out, instqueue_inst_en_out, instqueue_inst_out,
           instqueue_pc_out
  );

  modport slave (
    output ram_bus_rdy_in, ram_bus_en_in, ram_bus_inst_in, instqueue_rdy_in, rob_en_in, rob_pc_in,
    input  ram_bus_en_out, ram_bus_pc_out, instqueue_inst_en_out, instqueue_inst_out,
           instqueue_pc_out
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding memory request, DEPTH-entry FIFO of {inst, pc},
// flushed and re-pointed by ROB redirects.
module ifetch_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  ifetch_prefetch_if.master        bus,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               bus_en_q, bus_en_d;
  logic [ADDR_W-1:0]  bus_pc_q, bus_pc_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INST_W-1:0]  inst_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
  logic               push, pop, not_empty;

  assign not_empty = (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    bus_en_d   = 1'b0;
    bus_pc_d   = bus_pc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (rdy_in) begin
      pop = not_empty && bus.instqueue_rdy_in && !bus.rob_en_in;
      case (state_q)
        StIdle: begin
          if (!bus.rob_en_in && bus.ram_bus_rdy_in && (cnt_q < CNT_W'(DEPTH))) begin
            bus_en_d = 1'b1;
            bus_pc_d = fetch_pc_q;
            req_pc_d = fetch_pc_q;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (bus.rob_en_in) begin
            // A response arriving with the redirect is already stale.
            state_d = bus.ram_bus_en_in ? StIdle : StDrain;
          end else if (bus.ram_bus_en_in) begin
            push       = 1'b1;
            fetch_pc_d = req_pc_q + ADDR_W'(PC_STEP);
            state_d    = StIdle;
          end
        end
        StDrain: begin
          if (bus.ram_bus_en_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      if (bus.rob_en_in) begin
        fetch_pc_d = bus.rob_pc_in;
        rptr_d     = '0;
        wptr_d     = '0;
        cnt_d      = '0;
      end else begin
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      bus_en_q   <= 1'b0;
      bus_pc_q   <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      bus_en_q   <= bus_en_d;
      bus_pc_q   <= bus_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: the head outputs are masked while empty.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      inst_mem_q[wptr_q] <= bus.ram_bus_inst_in;
      pc_mem_q[wptr_q]   <= req_pc_q;
    end
  end

  assign bus.ram_bus_en_out        = bus_en_q;
  assign bus.ram_bus_pc_out        = bus_pc_q;
  assign bus.instqueue_inst_en_out = not_empty;
  assign bus.instqueue_inst_out    = not_empty ? inst_mem_q[rptr_q] : '0;
  assign bus.instqueue_pc_out      = not_empty ? pc_mem_q[rptr_q] : '0;
  assign count_out                 = cnt_q;

endmodule
